pipe_adder: RTL

Parametrised, pipelined ripple-chunk adder/subtractor with a valid/ready handshake. It generalises the team's single-bit full adder to WIDTH bits. The operands are split into CHUNK-bit slices, one slice per pipeline stage, with the carry registered between stages. It provides the modular 32-bit additions that the hashing datapath needs and runs at full clock rate on wide words.

---
 rtl/pipe_adder.sv | 98 +++++++++
 1 files changed

// File: rtl/pipe_adder.sv
// Pipelined ripple-chunk adder/subtractor: one CHUNK-bit slice per stage, carry registered
// between stages, a single stall enable (adv) freezing the whole pipe under backpressure.
module pipe_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / CHUNK;

    logic                adv;
    logic [STAGES-1:0]   vld_q;
    logic [STAGES-1:0]   c_q;
    logic [STAGES-1:0]   c_d;
    logic                ovf_q;
    logic                ovf_d;
    // a_q holds operand A with already-added slices overwritten by their result slices
    logic [WIDTH-1:0]    a_q [STAGES];
    logic [WIDTH-1:0]    a_d [STAGES];
    logic [WIDTH-1:0]    b_q [STAGES];

    logic [STAGES-1:0]   v_in_w;
    logic [STAGES-1:0]   c_in_w;
    logic [WIDTH-1:0]    a_in_w [STAGES];
    logic [WIDTH-1:0]    b_in_w [STAGES];

    assign adv      = !vld_q[STAGES-1] || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic [WIDTH-1:0] SLICE_M = WIDTH'({CHUNK{1'b1}}) << (k * CHUNK);
        logic [CHUNK:0] part_w;

        if (k == 0) begin : g_first
            assign v_in_w[k] = in_valid;
            assign a_in_w[k] = a;
            assign b_in_w[k] = sub ? ~b : b;
            assign c_in_w[k] = sub ? ~cin : cin;
        end else begin : g_link
            assign v_in_w[k] = vld_q[k-1];
            assign a_in_w[k] = a_q[k-1];
            assign b_in_w[k] = b_q[k-1];
            assign c_in_w[k] = c_q[k-1];
        end

        assign part_w = {1'b0, a_in_w[k][k*CHUNK +: CHUNK]}
                      + {1'b0, b_in_w[k][k*CHUNK +: CHUNK]}
                      + {{CHUNK{1'b0}}, c_in_w[k]};
        assign c_d[k] = part_w[CHUNK];
        assign a_d[k] = (a_in_w[k] & ~SLICE_M)
                      | (WIDTH'(part_w[CHUNK-1:0]) << (k * CHUNK));

        // The MSB slice of A is still the original operand bit when the last stage computes
        if (k == STAGES - 1) begin : g_last
            assign ovf_d = (a_in_w[k][WIDTH-1] == b_in_w[k][WIDTH-1])
                        && (part_w[CHUNK-1] != a_in_w[k][WIDTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else if (adv) begin
            vld_q <= v_in_w;
            c_q   <= c_d;
            ovf_q <= ovf_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_in_w[k];
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign sum       = a_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule
